// File: rtl/display_scan_controller.sv
// Push-button stepped multi-digit counter with a time-multiplexed
// 7-segment scan. The raw button is synchronised and debounced, and each
// accepted press becomes a one-cycle step. That step moves a cascaded
// per-digit counter. One shared decoder drives the digits in turn, with a
// one-cycle blanking gap between digit slots.
//
// Handshake note: there is no valid/ready traffic here. The only internal
// "transaction" is step_pulse. It is a single-cycle strobe that the counter
// consumes in the same cycle it is high, and it carries no back-pressure.
module display_scan_controller #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE       = 16,
    parameter int HEX            = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  input_clock1_1,
    input  logic                  input_reset_n2_2,
    input  logic                  input_push_button3_3,
    input  logic                  input_clear4_4,
    input  logic                  input_down5_5,
    output logic [6:0]            output_seg6_6,
    output logic                  output_dp7_7,
    output logic [DIGITS-1:0]     output_digit_en8_8,
    output logic [4*DIGITS-1:0]   output_count9_9,
    output logic                  output_overflow10_10,
    output logic                  debug_state
);

    localparam int SLOT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE + 1);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] DIGIT_MAX = (HEX != 0) ? 4'hF : 4'h9;
    localparam logic       INV       = (SEG_ACTIVE_LOW != 0);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    logic                  sync1, sync2;
    logic [DEB_W-1:0]      deb_cnt;
    logic                  deb_level;
    logic                  step_pulse;

    logic [4*DIGITS-1:0]   count, count_next;
    logic                  wrap;
    logic                  overflow;

    scan_state_t           state, state_next;
    logic [IDX_W-1:0]      index, index_next;
    logic [SLOT_W-1:0]     slot, slot_next;
    logic [6:0]            seg_raw, seg_raw_next;
    logic [3:0]            cur_digit;
    logic [6:0]            seg_decoded;
    logic [DIGITS-1:0]     digit_en;
    logic                  dp_raw;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge input_clock1_1 or negedge input_reset_n2_2) begin
        if (!input_reset_n2_2) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= input_push_button3_3;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a level change after DEBOUNCE consecutive differing
    // samples, and emit a one-cycle step strobe on the accepted rising level.
    always_ff @(posedge input_clock1_1 or negedge input_reset_n2_2) begin
        if (!input_reset_n2_2) begin
            deb_cnt    <= '0;
            deb_level  <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (sync2 == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEBOUNCE - 1)) begin
                deb_cnt    <= '0;
                deb_level  <= ~deb_level;
                step_pulse <= ~deb_level;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Ripple carry/borrow through all digits in one cycle.
    // wrap is set when every digit rolled over.
    always_comb begin
        logic       carry;
        logic [3:0] digit;
        logic [3:0] nd;
        count_next = count;
        carry      = 1'b1;
        digit      = '0;
        nd         = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count[4*i +: 4];
            nd    = digit;
            if (carry) begin
                if (!input_down5_5) begin
                    if (digit == DIGIT_MAX) begin
                        nd = 4'h0;
                    end else begin
                        nd    = digit + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == 4'h0) begin
                        nd = DIGIT_MAX;
                    end else begin
                        nd    = digit - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            count_next[4*i +: 4] = nd;
        end
        wrap = carry;
    end

    // Count register: clear has priority over a step and suppresses overflow.
    always_ff @(posedge input_clock1_1 or negedge input_reset_n2_2) begin
        if (!input_reset_n2_2) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (input_clear4_4) begin
                count <= '0;
            end else if (step_pulse) begin
                count    <= count_next;
                overflow <= wrap;
            end
        end
    end

    // Hex/decimal 7-segment decode of the digit currently selected by the scan.
    always_comb begin
        cur_digit = count[4*int'(index) +: 4];
        case (cur_digit)
            4'h0: seg_decoded = 7'h3F;
            4'h1: seg_decoded = 7'h06;
            4'h2: seg_decoded = 7'h5B;
            4'h3: seg_decoded = 7'h4F;
            4'h4: seg_decoded = 7'h66;
            4'h5: seg_decoded = 7'h6D;
            4'h6: seg_decoded = 7'h7D;
            4'h7: seg_decoded = 7'h07;
            4'h8: seg_decoded = 7'h7F;
            4'h9: seg_decoded = 7'h6F;
            4'hA: seg_decoded = 7'h77;
            4'hB: seg_decoded = 7'h7C;
            4'hC: seg_decoded = 7'h39;
            4'hD: seg_decoded = 7'h5E;
            4'hE: seg_decoded = 7'h79;
            4'hF: seg_decoded = 7'h71;
            default: seg_decoded = 7'h00;
        endcase
    end

    // Scan state register along with digit index, slot timer and latched segments.
    always_ff @(posedge input_clock1_1 or negedge input_reset_n2_2) begin
        if (!input_reset_n2_2) begin
            state   <= BLANK;
            index   <= '0;
            slot    <= '0;
            seg_raw <= '0;
        end else begin
            state   <= state_next;
            index   <= index_next;
            slot    <= slot_next;
            seg_raw <= seg_raw_next;
        end
    end

    // Scan next-state and outputs: one blank cycle latches the segments,
    // then SCAN_DIV-1 drive cycles enable the selected digit.
    always_comb begin
        state_next   = state;
        index_next   = index;
        slot_next    = slot;
        seg_raw_next = seg_raw;
        digit_en     = '0;
        dp_raw       = 1'b0;
        case (state)
            BLANK: begin
                seg_raw_next = seg_decoded;
                slot_next    = '0;
                state_next   = DRIVE;
            end
            DRIVE: begin
                digit_en = DIGITS'(1) << index;
                dp_raw   = (index == '0) && deb_level;
                if (slot == SLOT_W'(SCAN_DIV - 2)) begin
                    slot_next  = '0;
                    state_next = BLANK;
                    index_next = (index == IDX_W'(DIGITS - 1)) ? '0 : index + 1'b1;
                end else begin
                    slot_next = slot + 1'b1;
                end
            end
            default: begin
                state_next = BLANK;
            end
        endcase
    end

    assign output_seg6_6        = seg_raw ^ {7{INV}};
    assign output_dp7_7         = dp_raw ^ INV;
    assign output_digit_en8_8   = digit_en;
    assign output_count9_9      = count;
    assign output_overflow10_10 = overflow;
    assign debug_state          = state;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller. Two instances with different
// parameters share one set of stimulus. Every cycle the bench compares
// both instances against a reference model built from cycle counts,
// sample windows and integer counter arithmetic.
module tb_display_scan_controller;

  localparam int A_DIG = 4, A_SCAN = 4, A_DEB = 16, A_HEX = 0, A_SAL = 0;
  localparam int B_DIG = 3, B_SCAN = 5, B_DEB = 3,  B_HEX = 1, B_SAL = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic clear = 1'b0;
  logic down = 1'b0;

  logic [6:0]         seg_a, seg_b;
  logic               dp_a, dp_b;
  logic [A_DIG-1:0]   en_a;
  logic [B_DIG-1:0]   en_b;
  logic [4*A_DIG-1:0] cnt_a;
  logic [4*B_DIG-1:0] cnt_b;
  logic               ovf_a, ovf_b;
  logic               st_a, st_b;

  display_scan_controller #(
    .DIGITS(A_DIG), .SCAN_DIV(A_SCAN), .DEBOUNCE(A_DEB), .HEX(A_HEX), .SEG_ACTIVE_LOW(A_SAL)
  ) dut_a (
    .input_clock1_1(clk), .input_reset_n2_2(rst_n), .input_push_button3_3(btn),
    .input_clear4_4(clear), .input_down5_5(down), .output_seg6_6(seg_a),
    .output_dp7_7(dp_a), .output_digit_en8_8(en_a), .output_count9_9(cnt_a),
    .output_overflow10_10(ovf_a), .debug_state(st_a)
  );

  display_scan_controller #(
    .DIGITS(B_DIG), .SCAN_DIV(B_SCAN), .DEBOUNCE(B_DEB), .HEX(B_HEX), .SEG_ACTIVE_LOW(B_SAL)
  ) dut_b (
    .input_clock1_1(clk), .input_reset_n2_2(rst_n), .input_push_button3_3(btn),
    .input_clear4_4(clear), .input_down5_5(down), .output_seg6_6(seg_b),
    .output_dp7_7(dp_b), .output_digit_en8_8(en_b), .output_count9_9(cnt_b),
    .output_overflow10_10(ovf_b), .debug_state(st_b)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int ovf_seen_a = 0;

  // per-instance parameters seen by the model
  int p_dig[2]  = '{A_DIG, B_DIG};
  int p_scan[2] = '{A_SCAN, B_SCAN};
  int p_deb[2]  = '{A_DEB, B_DEB};
  int p_hex[2]  = '{A_HEX, B_HEX};
  int p_sal[2]  = '{A_SAL, B_SAL};

  int seg_tab[16] = '{32'h3F, 32'h06, 32'h5B, 32'h4F, 32'h66, 32'h6D, 32'h7D, 32'h07,
                      32'h7F, 32'h6F, 32'h77, 32'h7C, 32'h39, 32'h5E, 32'h79, 32'h71};
  int scan_seq[16] = '{0, 1, 1, 1, 0, 2, 2, 2, 0, 4, 4, 4, 0, 8, 8, 8};

  // reference model state
  int m_t[2];        // cycles since reset release
  int m_val[2];      // counter value as a plain integer
  bit m_deb[2];      // accepted button level
  bit m_pend[2];     // an accepted press that is applied on the next edge
  bit m_ovf[2];
  int m_segraw[2];   // segment pattern latched at the last blank slot
  bit hist[$];       // raw button levels at the two previous edges
  bit samp[$];       // synchronised samples, newest last

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int modulus(input int u);
    int m = 1;
    for (int i = 0; i < p_dig[u]; i++) m = m * ((p_hex[u] != 0) ? 16 : 10);
    return m;
  endfunction

  function automatic int digit_of(input int u, input int val, input int d);
    int base = (p_hex[u] != 0) ? 16 : 10;
    int v = val;
    for (int i = 0; i < d; i++) v = v / base;
    return v % base;
  endfunction

  function automatic logic [31:0] pack(input int u, input int val);
    logic [31:0] r = '0;
    for (int i = 0; i < p_dig[u]; i++) r = r | (32'(digit_of(u, val, i)) << (4 * i));
    return r;
  endfunction

  function automatic bit window_differs(input int u);
    if (samp.size() < p_deb[u]) return 1'b0;
    for (int k = 0; k < p_deb[u]; k++)
      if (samp[samp.size() - 1 - k] == m_deb[u]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist = '{1'b0, 1'b0};
    samp.delete();
    for (int k = 0; k < 16; k++) samp.push_back(1'b0);
    for (int u = 0; u < 2; u++) begin
      m_t[u] = 0; m_val[u] = 0; m_deb[u] = 0; m_pend[u] = 0; m_ovf[u] = 0; m_segraw[u] = 0;
    end
  endtask

  // advance the model by one rising edge using the inputs held before it
  task automatic model_edge();
    bit s;
    if (!rst_n) return;
    s = hist.pop_front();
    hist.push_back(btn);
    samp.push_back(s);
    if (samp.size() > 16) void'(samp.pop_front());
    for (int u = 0; u < 2; u++) begin
      int phase = m_t[u] % p_scan[u];
      int dig = (m_t[u] / p_scan[u]) % p_dig[u];
      int top = modulus(u) - 1;
      if (phase == 0) m_segraw[u] = seg_tab[digit_of(u, m_val[u], dig)];
      m_ovf[u] = 1'b0;
      if (clear) m_val[u] = 0;
      else if (m_pend[u]) begin
        if (down) begin
          if (m_val[u] == 0) begin m_val[u] = top; m_ovf[u] = 1'b1; end
          else m_val[u] = m_val[u] - 1;
        end else begin
          if (m_val[u] == top) begin m_val[u] = 0; m_ovf[u] = 1'b1; end
          else m_val[u] = m_val[u] + 1;
        end
      end
      m_pend[u] = 1'b0;
      if (window_differs(u)) begin
        m_deb[u] = ~m_deb[u];
        m_pend[u] = m_deb[u];
      end
      m_t[u] = m_t[u] + 1;
    end
  endtask

  task automatic expect_outputs(input int u, output logic [31:0] e_en, output logic [31:0] e_seg,
                                output logic [31:0] e_dp, output logic [31:0] e_cnt,
                                output logic [31:0] e_ovf, output logic [31:0] e_st);
    int phase = m_t[u] % p_scan[u];
    int dig = (m_t[u] / p_scan[u]) % p_dig[u];
    bit drive = (phase != 0);
    e_en  = drive ? (32'd1 << dig) : 32'd0;
    e_seg = 32'(m_segraw[u]) ^ ((p_sal[u] != 0) ? 32'h7F : 32'h0);
    e_dp  = 32'(drive && dig == 0 && m_deb[u]) ^ 32'(p_sal[u] != 0);
    e_cnt = pack(u, m_val[u]);
    e_ovf = 32'(m_ovf[u]);
    e_st  = 32'(drive);
  endtask

  task automatic check_all();
    logic [31:0] e_en, e_seg, e_dp, e_cnt, e_ovf, e_st;
    expect_outputs(0, e_en, e_seg, e_dp, e_cnt, e_ovf, e_st);
    chk("a_digit_en", 32'(en_a), e_en);
    chk("a_seg", 32'(seg_a), e_seg);
    chk("a_dp", 32'(dp_a), e_dp);
    chk("a_count", 32'(cnt_a), e_cnt);
    chk("a_overflow", 32'(ovf_a), e_ovf);
    chk("a_state", 32'(st_a), e_st);
    expect_outputs(1, e_en, e_seg, e_dp, e_cnt, e_ovf, e_st);
    chk("b_digit_en", 32'(en_b), e_en);
    chk("b_seg", 32'(seg_b), e_seg);
    chk("b_dp", 32'(dp_b), e_dp);
    chk("b_count", 32'(cnt_b), e_cnt);
    chk("b_overflow", 32'(ovf_b), e_ovf);
    chk("b_state", 32'(st_b), e_st);
  endtask

  // driver: one clock edge, model update, then compare away from the edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic press(input int hi, input int lo);
    ovf_seen_a = 0;
    btn = 1'b1;
    repeat (hi) begin tick(); if (ovf_a) ovf_seen_a++; end
    btn = 1'b0;
    repeat (lo) begin tick(); if (ovf_a) ovf_seen_a++; end
  endtask

  initial begin
    bit ok;
    // reset held from time zero
    model_reset();
    #1;
    check_all();
    repeat (3) tick();
    chk("reset_seg_b_active_low", 32'(seg_b), 32'h7F);
    rst_n = 1'b1;

    // idle scan: two full frames of instance a
    chk("scan_seq_t0", 32'(en_a), 32'(scan_seq[0]));
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("scan_seq", 32'(en_a), 32'(scan_seq[i % 16]));
      if (scan_seq[i % 16] != 0) chk("idle_seg_zero", 32'(seg_a), 32'h3F);
    end

    // clean press held 100 cycles: the count changes at edge 19
    btn = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 18) chk("press_cnt_before", 32'(cnt_a), 32'h0);
      if (k == 19) chk("press_cnt_at19", 32'(cnt_a), 32'h1);
    end
    btn = 1'b0;
    repeat (60) tick();
    chk("release_no_step", 32'(cnt_a), 32'h1);

    // bouncy press, then held high
    for (int p = 0; p < 5; p++) begin
      btn = 1'b1; repeat (3) tick();
      btn = 1'b0; repeat (3) tick();
    end
    btn = 1'b1; repeat (40) tick();
    chk("bounce_one_step", 32'(cnt_a), 32'h2);
    btn = 1'b0; repeat (40) tick();

    // randomised button, direction and clear
    for (int seg_i = 0; seg_i < 120; seg_i++) begin
      int hold = $urandom_range(1, 30);
      btn = 1'($urandom_range(0, 1));
      down = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 15) == 0);
      tick();
      clear = 1'b0;
      repeat (hold - 1) tick();
    end
    btn = 1'b0; down = 1'b0;
    repeat (25) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_to_zero", 32'(cnt_a), 32'h0);

    // count up to 42 (decimal digits on a)
    for (int n = 0; n < 42; n++) press(20, 22);
    chk("count_42", 32'(cnt_a), 32'h0042);

    // clear in the same cycle as a step: clear wins, no overflow
    ok = 1'b0;
    btn = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (m_pend[0]) ok = 1'b1;
      else tick();
    end
    chk("wait_step_pulse", 32'(ok), 32'h1);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_vs_step_cnt", 32'(cnt_a), 32'h0);
    chk("clear_vs_step_ovf", 32'(ovf_a), 32'h0);
    tick();
    chk("clear_vs_step_ovf_late", 32'(ovf_a), 32'h0);
    btn = 1'b0; repeat (22) tick();

    // borrow wrap from zero, then carry wrap back
    down = 1'b1;
    press(20, 22);
    chk("wrap_down_cnt", 32'(cnt_a), 32'h9999);
    chk("wrap_down_ovf_pulses", 32'(ovf_seen_a), 32'd1);
    down = 1'b0;
    press(20, 22);
    chk("wrap_up_cnt", 32'(cnt_a), 32'h0000);
    chk("wrap_up_ovf_pulses", 32'(ovf_seen_a), 32'd1);
    press(20, 22);
    chk("step_after_wrap", 32'(cnt_a), 32'h0001);

    // asynchronous reset in the middle of digit 2's drive slot, with the
    // button held so that debouncing is in progress
    btn = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      if ((m_t[0] % A_SCAN) == 2 && ((m_t[0] / A_SCAN) % A_DIG) == 2) ok = 1'b1;
      else tick();
    end
    chk("wait_digit2", 32'(ok), 32'h1);
    chk("mid_drive_en", 32'(en_a), 32'h4);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_en", 32'(en_a), 32'h0);
    chk("async_rst_seg_a", 32'(seg_a), 32'h0);
    chk("async_rst_seg_b", 32'(seg_b), 32'h7F);
    chk("async_rst_cnt", 32'(cnt_a), 32'h0);
    check_all();
    btn = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("restart_blank", 32'(en_a), 32'h0);
    tick();
    chk("restart_digit0", 32'(en_a), 32'h1);
    repeat (60) tick();
    chk("no_step_after_rst", 32'(cnt_a), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
